// File: rtl/ibex_multdiv_iter_if.sv
// Request/response bundle between a pipeline front end and the iterative mul/div unit.
// Signal names follow the unit's port list; the slave modport is the unit's side.
interface ibex_multdiv_iter_if #(
    parameter int WIDTH = 32
);
    logic             req_valid_i;
    logic             req_ready_o;
    logic [2:0]       op_i;
    logic [WIDTH-1:0] op_a_i;
    logic [WIDTH-1:0] op_b_i;
    logic             flush_i;
    logic             resp_valid_o;
    logic             resp_ready_i;
    logic [WIDTH-1:0] result_o;

    modport master (
        output req_valid_i, op_i, op_a_i, op_b_i, flush_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, result_o
    );

    modport slave (
        input  req_valid_i, op_i, op_a_i, op_b_i, flush_i, resp_ready_i,
        output req_ready_o, resp_valid_o, result_o
    );
endinterface

// File: rtl/ibex_multdiv_iter.sv
// Iterative RISC-V M-extension unit: chunked multiply (KW bits per cycle) and
// restoring division (one quotient bit per cycle), sign handled outside the core loops.
module ibex_multdiv_iter #(
    parameter int WIDTH = 32,
    parameter int KW    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    ibex_multdiv_iter_if.slave   bus
);
    localparam int NCH = WIDTH / KW;
    localparam int CW  = $clog2(WIDTH);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [2:0] {
        IDLE,
        ABS,
        MUL,
        DIV,
        SIGN,
        DONE
    } state_e;

    state_e               state_q, state_d;
    logic [2:0]           op_q;
    logic [WIDTH-1:0]     a_q, b_q;
    logic [WIDTH-1:0]     a_mag_q, b_mag_q;
    logic                 neg_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [CW-1:0]        cnt_q;
    logic [WIDTH-1:0]     result_q;

    logic                 accept;
    logic                 is_div, is_rem, div_zero;
    logic                 sign_a, sign_b, neg_d;
    logic [WIDTH-1:0]     a_abs, b_abs, div_zero_result;
    logic                 mul_last, div_last;
    logic [WIDTH+KW-1:0]  pp;
    logic [2*WIDTH-1:0]   pp_ext, mul_next;
    logic [WIDTH:0]       rem_shift, diff;
    logic [2*WIDTH-1:0]   div_next, prod_fix;
    logic [WIDTH-1:0]     sign_result;

    // Operand classification is taken from the captured opcode, never the live inputs.
    always_comb begin
        accept          = (state_q == IDLE) && bus.req_valid_i && !bus.flush_i;
        is_div          = op_q[2];
        is_rem          = op_q[2] & op_q[1];
        sign_a          = (op_q inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) & a_q[WIDTH-1];
        sign_b          = (op_q inside {OP_MULH, OP_DIV, OP_REM}) & b_q[WIDTH-1];
        neg_d           = is_rem ? sign_a : (sign_a ^ sign_b);
        a_abs           = sign_a ? -a_q : a_q;
        b_abs           = sign_b ? -b_q : b_q;
        div_zero        = is_div && (b_q == '0);
        div_zero_result = is_rem ? a_q : '1;
        mul_last        = (cnt_q == CW'(NCH - 1));
        div_last        = (cnt_q == CW'(WIDTH - 1));
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        pp       = {{KW{1'b0}}, a_mag_q} * {{WIDTH{1'b0}}, b_mag_q[KW-1:0]};
        pp_ext   = '0;
        pp_ext[WIDTH+KW-1:0] = pp;
        mul_next = acc_q + (pp_ext << (int'(cnt_q) * KW));

        // Restoring step: the remainder lives in the upper half, the dividend/quotient in the lower.
        rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff      = rem_shift - {1'b0, b_mag_q};
        if (!diff[WIDTH]) begin
            div_next = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end

        prod_fix    = neg_q ? -acc_q : acc_q;
        sign_result = '0;
        if (!is_div) begin
            sign_result = (op_q == OP_MUL) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
        end else if (is_rem) begin
            sign_result = neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end else begin
            sign_result = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        end
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        bus.req_ready_o  = (state_q == IDLE);
        bus.resp_valid_o = (state_q == DONE);
        bus.result_o     = result_q;
        unique case (state_q)
            IDLE: if (accept) state_d = ABS;
            ABS: begin
                if (!is_div)       state_d = MUL;
                else if (div_zero) state_d = DONE;
                else               state_d = DIV;
            end
            MUL:  if (mul_last) state_d = SIGN;
            DIV:  if (div_last) state_d = SIGN;
            SIGN: state_d = DONE;
            DONE: if (bus.resp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort wins over completion and acceptance alike.
        if (bus.flush_i) state_d = IDLE;
    end

    // NOTE: datapath registers are reset too, because result_o must read zero out of reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            a_mag_q  <= '0;
            b_mag_q  <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q <= bus.op_i;
                        a_q  <= bus.op_a_i;
                        b_q  <= bus.op_b_i;
                    end
                end
                ABS: begin
                    a_mag_q <= a_abs;
                    b_mag_q <= b_abs;
                    neg_q   <= neg_d;
                    cnt_q   <= '0;
                    acc_q   <= is_div ? {{WIDTH{1'b0}}, a_abs} : '0;
                    if (div_zero) result_q <= div_zero_result;
                end
                MUL: begin
                    acc_q   <= mul_next;
                    b_mag_q <= b_mag_q >> KW;
                    cnt_q   <= mul_last ? '0 : cnt_q + CW'(1);
                end
                DIV: begin
                    acc_q <= div_next;
                    cnt_q <= div_last ? '0 : cnt_q + CW'(1);
                end
                SIGN: result_q <= sign_result;
                default: ;
            endcase
        end
    end
endmodule
